udp_img_line_ctrl: RTL

//  Sequences UDP image payload words from the UDP RX parser into the frame-buffer write path.

---
 rtl/udp_img_pkg.sv | 18 +
 rtl/udp_img_addr_gen.sv | 62 ++++++
 rtl/udp_img_line_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/udp_img_pkg.sv
// Shared constants for the UDP image line controller: header layout and FSM states.
package udp_img_pkg;

    localparam logic [7:0]  HDR_MAGIC     = 8'hA5;
    localparam int unsigned HDR_MAGIC_MSB = 31;
    localparam int unsigned HDR_MAGIC_LSB = 24;
    localparam int unsigned HDR_SOF_BIT   = 23;
    localparam int unsigned HDR_IDX_MSB   = 22;
    localparam int unsigned HDR_IDX_LSB   = 12;
    localparam int unsigned LINE_IDX_W    = HDR_IDX_MSB - HDR_IDX_LSB + 1;

    typedef enum logic [1:0] {
        ST_HDR  = 2'd0,
        ST_DATA = 2'd1,
        ST_DROP = 2'd2
    } rx_state_e;

endpackage

// File: rtl/udp_img_addr_gen.sv
// Frame-buffer address generator: line base, word index within line, and bank ping-pong.
module udp_img_addr_gen #(
    parameter int unsigned       LINE_WORDS = 320,
    parameter int unsigned       WIDX_W     = 9,
    parameter int unsigned       ADDR_W     = 28,
    parameter logic [ADDR_W-1:0] BANK0_BASE = '0,
    parameter logic [ADDR_W-1:0] BANK1_BASE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              base_load,
    input  logic              line_adv,
    input  logic              frame_adv,
    input  logic              word_clr,
    input  logic              word_inc,
    output logic [WIDX_W-1:0] word_idx,
    output logic              frame_bank,
    output logic [ADDR_W-1:0] cur_addr
);
    import udp_img_pkg::*;

    localparam logic [ADDR_W-1:0] LW_A = ADDR_W'(LINE_WORDS);
    localparam logic [WIDX_W-1:0] LW_W = WIDX_W'(LINE_WORDS);

    logic [ADDR_W-1:0] line_base_q, line_base_d;
    logic [WIDX_W-1:0] word_idx_q, word_idx_d;
    logic              bank_q, bank_d;

    always_comb begin
        line_base_d = line_base_q;
        word_idx_d  = word_idx_q;
        bank_d      = bank_q;
        if (base_load)
            line_base_d = bank_q ? BANK1_BASE : BANK0_BASE;
        else if (line_adv)
            line_base_d = line_base_q + LW_A;
        // Index saturates at LINE_WORDS; overflow words are flagged bad by the FSM.
        if (word_clr)
            word_idx_d = '0;
        else if (word_inc && word_idx_q != LW_W)
            word_idx_d = word_idx_q + 1'b1;
        if (frame_adv)
            bank_d = ~bank_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line_base_q <= '0;
            word_idx_q  <= '0;
            bank_q      <= 1'b0;
        end else begin
            line_base_q <= line_base_d;
            word_idx_q  <= word_idx_d;
            bank_q      <= bank_d;
        end
    end

    assign word_idx   = word_idx_q;
    assign frame_bank = bank_q;
    assign cur_addr   = line_base_q + ADDR_W'(word_idx_q);

endmodule

// File: rtl/udp_img_line_ctrl.sv
// UDP image line sequencer: header check, line ordering, frame-buffer writes.
// Optional counters pkt_err_cnt/frame_cnt exist when UDP_IMG_STATS_EN is defined.
module udp_img_line_ctrl #(
    parameter int unsigned       IMG_WIDTH  = 640,
    parameter int unsigned       IMG_HEIGHT = 480,
    parameter int unsigned       BYTES_PIX  = 2,
    parameter int unsigned       ADDR_W     = 28,
    parameter logic [ADDR_W-1:0] BANK0_BASE = 28'h0000000,
    parameter logic [ADDR_W-1:0] BANK1_BASE = 28'h0100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rec_en,
    input  logic [31:0]       rec_data,
    input  logic              rec_pkt_done,
    input  logic [15:0]       rec_byte_num,
    input  logic              wr_full,
    output logic              wr_en,
    output logic [31:0]       wr_data,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              line_done,
    output logic              frame_done,
    output logic              frame_bank,
`ifdef UDP_IMG_STATS_EN
    output logic [15:0]       pkt_err_cnt,
    output logic [15:0]       frame_cnt,
`endif
    output logic              rx_busy
);
    import udp_img_pkg::*;

    localparam int unsigned LINE_WORDS = IMG_WIDTH * BYTES_PIX / 4;
    localparam int unsigned WIDX_W     = $clog2(LINE_WORDS + 1);
    localparam logic [WIDX_W-1:0]     LW_W      = WIDX_W'(LINE_WORDS);
    localparam logic [15:0]           PKT_BYTES = 16'(4 + LINE_WORDS * 4);
    localparam logic [LINE_IDX_W-1:0] LAST_LINE = LINE_IDX_W'(IMG_HEIGHT - 1);

    rx_state_e               state_q, state_d;
    logic                    frame_active_q, frame_active_d;
    logic [LINE_IDX_W-1:0]   exp_line_q, exp_line_d;
    logic                    bad_q, bad_d;
    logic                    wr_en_q, wr_en_d;
    logic [31:0]             wr_data_q, wr_data_d;
    logic [ADDR_W-1:0]       wr_addr_q, wr_addr_d;
    logic                    line_done_q, line_done_d;
    logic                    frame_done_q, frame_done_d;

    logic                    base_load, line_adv, frame_adv, word_clr, word_inc;
    logic [WIDX_W-1:0]       word_idx, widx_next;
    logic [ADDR_W-1:0]       cur_addr;
    logic                    bad_next, line_good;
    logic                    magic_ok, hdr_sof, sof_ok, cont_ok, hdr_ok;
    logic [LINE_IDX_W-1:0]   hdr_idx;

    udp_img_addr_gen #(
        .LINE_WORDS (LINE_WORDS),
        .WIDX_W     (WIDX_W),
        .ADDR_W     (ADDR_W),
        .BANK0_BASE (BANK0_BASE),
        .BANK1_BASE (BANK1_BASE)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .base_load  (base_load),
        .line_adv   (line_adv),
        .frame_adv  (frame_adv),
        .word_clr   (word_clr),
        .word_inc   (word_inc),
        .word_idx   (word_idx),
        .frame_bank (frame_bank),
        .cur_addr   (cur_addr)
    );

    assign magic_ok = rec_data[HDR_MAGIC_MSB:HDR_MAGIC_LSB] == HDR_MAGIC;
    assign hdr_sof  = rec_data[HDR_SOF_BIT];
    assign hdr_idx  = rec_data[HDR_IDX_MSB:HDR_IDX_LSB];
    assign sof_ok   = magic_ok && hdr_sof && hdr_idx == '0;
    assign cont_ok  = magic_ok && !hdr_sof && frame_active_q && hdr_idx == exp_line_q;
    assign hdr_ok   = sof_ok || cont_ok;

    always_comb begin
        state_d        = state_q;
        frame_active_d = frame_active_q;
        exp_line_d     = exp_line_q;
        bad_d          = bad_q;
        wr_en_d        = 1'b0;
        wr_data_d      = wr_data_q;
        wr_addr_d      = wr_addr_q;
        line_done_d    = 1'b0;
        frame_done_d   = 1'b0;
        base_load      = 1'b0;
        line_adv       = 1'b0;
        frame_adv      = 1'b0;
        word_clr       = 1'b0;
        word_inc       = 1'b0;
        widx_next      = word_idx;
        bad_next       = bad_q;
        line_good      = 1'b0;
        case (state_q)
            ST_HDR: begin
                // A packet ending on (or before) its header carries no line.
                if (!rec_pkt_done && rec_en) begin
                    if (hdr_ok) begin
                        state_d  = ST_DATA;
                        word_clr = 1'b1;
                        bad_d    = 1'b0;
                        if (sof_ok) begin
                            frame_active_d = 1'b1;
                            exp_line_d     = '0;
                            base_load      = 1'b1;
                        end
                    end else begin
                        state_d        = ST_DROP;
                        frame_active_d = 1'b0;
                    end
                end
            end
            ST_DATA: begin
                if (rec_en) begin
                    word_inc = 1'b1;
                    if (word_idx == LW_W) begin
                        bad_next = 1'b1;
                    end else begin
                        widx_next = word_idx + 1'b1;
                        if (wr_full) begin
                            bad_next = 1'b1;
                        end else begin
                            wr_en_d   = 1'b1;
                            wr_data_d = rec_data;
                            wr_addr_d = cur_addr;
                        end
                    end
                end
                bad_d = bad_next;
                if (rec_pkt_done) begin
                    state_d   = ST_HDR;
                    line_good = rec_byte_num == PKT_BYTES && widx_next == LW_W && !bad_next;
                    if (line_good) begin
                        line_done_d = 1'b1;
                        line_adv    = 1'b1;
                        if (exp_line_q == LAST_LINE) begin
                            frame_done_d   = 1'b1;
                            frame_adv      = 1'b1;
                            exp_line_d     = '0;
                            frame_active_d = 1'b0;
                        end else begin
                            exp_line_d = exp_line_q + 1'b1;
                        end
                    end else begin
                        frame_active_d = 1'b0;
                    end
                end
            end
            ST_DROP: begin
                if (rec_pkt_done)
                    state_d = ST_HDR;
            end
            default: state_d = ST_HDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_HDR;
            frame_active_q <= 1'b0;
            exp_line_q     <= '0;
            bad_q          <= 1'b0;
            wr_en_q        <= 1'b0;
            wr_data_q      <= '0;
            wr_addr_q      <= '0;
            line_done_q    <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            frame_active_q <= frame_active_d;
            exp_line_q     <= exp_line_d;
            bad_q          <= bad_d;
            wr_en_q        <= wr_en_d;
            wr_data_q      <= wr_data_d;
            wr_addr_q      <= wr_addr_d;
            line_done_q    <= line_done_d;
            frame_done_q   <= frame_done_d;
        end
    end

`ifdef UDP_IMG_STATS_EN
    logic        pkt_err;
    logic [15:0] pkt_err_cnt_q, pkt_err_cnt_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;

    assign pkt_err = (state_q == ST_HDR && (rec_pkt_done || (rec_en && !hdr_ok))) ||
                     (state_q == ST_DATA && rec_pkt_done && !line_good);

    always_comb begin
        pkt_err_cnt_d = pkt_err_cnt_q;
        frame_cnt_d   = frame_cnt_q;
        if (pkt_err && pkt_err_cnt_q != '1)
            pkt_err_cnt_d = pkt_err_cnt_q + 1'b1;
        if (frame_done_d)
            frame_cnt_d = frame_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_err_cnt_q <= '0;
            frame_cnt_q   <= '0;
        end else begin
            pkt_err_cnt_q <= pkt_err_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign pkt_err_cnt = pkt_err_cnt_q;
    assign frame_cnt   = frame_cnt_q;
`endif

    assign wr_en      = wr_en_q;
    assign wr_data    = wr_data_q;
    assign wr_addr    = wr_addr_q;
    assign line_done  = line_done_q;
    assign frame_done = frame_done_q;
    assign rx_busy    = state_q != ST_HDR;

endmodule
